bullet_engine: RTL and testbench
================================

# bullet_engine

Projectile stage directly downstream of the keyboard-driven ship/ball motion block. It consumes the ship's integer position and its heading unit vector (X_vec/Y_vec), and spawns bullets when the fire key is held. Each bullet is stored in a fixed slot and advanced once per frame in 10.7 fixed point. Bullets are retired when they leave the screen. Registered per-slot positions and active flags go to the color mapper for drawing.

## Interface
- N_BULLETS, 4: number of bullet slots (1–8).
- COOLDOWN, 8: minimum frames between successive shots.
- FIRE_KEY, 8'h2C: USB HID usage code of the fire key (space).
- X_Max, 639: rightmost legal integer X.
- Y_Max, 479: bottommost legal integer Y.
- SPEED_SHIFT, 2: bullet velocity is the heading vector left-shifted by this amount.

- frame_clk  in  1  frame-rate clock, the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  64  eight packed 8-bit HID codes; byte i is keycode[8i+7:8i].
- Ship_X  in  10  ship integer X.
- Ship_Y  in  10  ship integer Y.
- X_vec  in  8  signed Q1.7 heading cosine.
- Y_vec  in  8  signed Q1.7 heading sine.
- Bullet_X  out  10*N_BULLETS  slot i integer X at [10i+9:10i].
- Bullet_Y  out  10*N_BULLETS  slot i integer Y.
- Bullet_Active  out  N_BULLETS  bit i set when slot i is live.
- Shots_Fired  out  8  running count of spawned bullets, wraps mod 256.

## Operation
- **Per-slot state:** pos_x, pos_y (17 bits, 10.7 unsigned); vel_x, vel_y (17 bits, two's complement); active (1 bit).
- **Fire detect:** fire = 1 when any of the 8 keycode bytes equals FIRE_KEY. The key is level-sensitive; holding it auto-fires.
- **Cooldown counter (clog2(COOLDOWN+1) bits):**
  - Decrements by 1 per frame while nonzero.
  - On a spawn it loads COOLDOWN-1.
  - Reset value is 0, so the first press fires immediately.
- **Spawn:** occurs when fire=1, cooldown=0, and at least one slot is inactive at the start of the cycle.
  - The lowest-index inactive slot is chosen.
  - pos_x ← {Ship_X,7'b0}; pos_y ← {Ship_Y,7'b0}.
  - vel_x ← sign_extend_17(X_vec) <<< SPEED_SHIFT; vel_y likewise from Y_vec.
  - The vector is latched at spawn; later heading changes do not affect a bullet in flight.
  - active ← 1; Shots_Fired increments.
- **No free slot:** the fire request is dropped. The cooldown is not reloaded and Shots_Fired is unchanged.
- **Advance:** each active slot not being spawned this cycle computes nx = pos_x + vel_x and ny = pos_y + vel_y, mod 2^17.
- **Retire:** if nx[16:7] > X_Max or ny[16:7] > Y_Max, active ← 0 and the position holds its old value.
  - Underflow below 0 wraps to integer ≥ 1000, which exceeds either max, so one compare handles both edges.
  - Otherwise pos ← next.
- **Slot reuse:** a slot retiring this cycle is not spawnable until the next cycle.
- **Inactive slots:** positions are don't-care internally, but Bullet_X/Bullet_Y for an inactive slot are driven to 0.
- **Outputs:** Bullet_X[i] = active ? pos_x[16:7] : 0, taken directly from registers with no combinational path from the inputs.

## Timing
- All state updates on posedge frame_clk.
- Reset_n low clears every register asynchronously and immediately:
  - all Bullet_X, Bullet_Y, Bullet_Active = 0;
  - Shots_Fired = 0; cooldown = 0.
- Reset asserted mid-flight discards all bullets; there is no partial state after release.
- **Spawn latency:** with fire sampled high at edge k, Bullet_Active[i] = 1 and Bullet_X[i] = Ship_X are visible after edge k. The first movement appears after edge k+1.
- **Auto-fire:** with the key held continuously and slots available, shots occur at edges k, k+COOLDOWN, k+2·COOLDOWN, and so on.
- **Retire latency:** the active flag falls at the same edge that would have produced the out-of-range position.

## Test plan
- **Reset:** Reset_n=0 mid-run with 3 live bullets → all outputs 0 before the next edge; after release, the first fire spawns into slot 0 with Shots_Fired=1.
- **Single shot:**
  - Stimulus: Ship=(320,240), X_vec=8'h40, Y_vec=0, keycode byte 3 = 8'h2C for one frame.
  - Response: slot 0 X=320, 322, 324, 326 on successive edges; Y stays 240; Shots_Fired=1.
- **Auto-fire cadence:** key held for 20 frames, COOLDOWN=8, with slots free → spawns at frames 0, 8, 16 into slots 0, 1, 2; Shots_Fired=3.
- **Slots full:**
  - Stimulus: X_vec=Y_vec=0 (stationary bullets), key held for 60 frames.
  - Response: exactly 4 spawns; Bullet_Active=4'b1111; Shots_Fired stays 4; no fifth spawn.
- **Right/bottom retire:**
  - X: Ship_X=636, X_vec=8'h40 → X=636, 638, then active drops at the edge where X would reach 640.
  - Y: Ship_Y=478, Y_vec=8'h40 → Y=478, then retire.
- **Left underflow and reuse:**
  - Stimulus: Ship_X=1, X_vec=8'hC0 (−2 px/frame), key held.
  - Response: retire on the second edge. The freed slot is not respawned in the same cycle it retires, and is respawned on the next cycle once cooldown=0.

Source files
------------

// File: rtl/bullet_engine.sv
// Bullet spawner and per-frame mover: fixed slots in 10.7 fixed point, retired off-screen,
// with registered positions and active flags for the color mapper.
module bullet_engine #(
    parameter int         N_BULLETS   = 4,
    parameter int         COOLDOWN    = 8,
    parameter logic [7:0] FIRE_KEY    = 8'h2C,
    parameter int         X_Max       = 639,
    parameter int         Y_Max       = 479,
    parameter int         SPEED_SHIFT = 2
) (
    input  logic                    frame_clk,
    input  logic                    Reset_n,
    input  logic [63:0]             keycode,
    input  logic [9:0]              Ship_X,
    input  logic [9:0]              Ship_Y,
    input  logic [7:0]              X_vec,
    input  logic [7:0]              Y_vec,
    output logic [10*N_BULLETS-1:0] Bullet_X,
    output logic [10*N_BULLETS-1:0] Bullet_Y,
    output logic [N_BULLETS-1:0]    Bullet_Active,
    output logic [7:0]              Shots_Fired
);

    localparam int            CW      = $clog2(COOLDOWN + 1);
    localparam logic [9:0]    X_LIM   = 10'(X_Max);
    localparam logic [9:0]    Y_LIM   = 10'(Y_Max);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN - 1);

    logic [16:0]          posX_q [N_BULLETS];
    logic [16:0]          posY_q [N_BULLETS];
    logic [16:0]          velX_q [N_BULLETS];
    logic [16:0]          velY_q [N_BULLETS];
    logic [16:0]          posX_d [N_BULLETS];
    logic [16:0]          posY_d [N_BULLETS];
    logic [16:0]          velX_d [N_BULLETS];
    logic [16:0]          velY_d [N_BULLETS];
    logic [16:0]          nextX  [N_BULLETS];
    logic [16:0]          nextY  [N_BULLETS];
    logic [N_BULLETS-1:0] active_q, active_d;
    logic [CW-1:0]        cool_q, cool_d;
    logic [7:0]           shots_q, shots_d;

    logic                 fire, spawn, freeFound;
    logic [N_BULLETS-1:0] spawnSel;
    logic [16:0]          extX, extY, spawnVelX, spawnVelY;

    assign extX      = {{9{X_vec[7]}}, X_vec};
    assign extY      = {{9{Y_vec[7]}}, Y_vec};
    assign spawnVelX = extX << SPEED_SHIFT;
    assign spawnVelY = extY << SPEED_SHIFT;

    // Only slots already free at the start of the frame are candidates, so a slot
    // retiring this frame cannot be refilled until the next one.
    always_comb begin
        fire      = 1'b0;
        freeFound = 1'b0;
        spawnSel  = '0;
        for (int b = 0; b < 8; b++) begin
            if (keycode[8*b +: 8] == FIRE_KEY) fire = 1'b1;
        end
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!active_q[i] && !freeFound) begin
                spawnSel[i] = 1'b1;
                freeFound   = 1'b1;
            end
        end
        spawn = fire && (cool_q == '0) && freeFound;
    end

    // Underflow past zero wraps to a huge integer, so the single upper-bound
    // compare also catches bullets leaving through the left or top edge.
    always_comb begin
        active_d = active_q;
        cool_d   = cool_q;
        shots_d  = shots_q;
        for (int i = 0; i < N_BULLETS; i++) begin
            posX_d[i] = posX_q[i];
            posY_d[i] = posY_q[i];
            velX_d[i] = velX_q[i];
            velY_d[i] = velY_q[i];
            nextX[i]  = posX_q[i] + velX_q[i];
            nextY[i]  = posY_q[i] + velY_q[i];
            if (spawn && spawnSel[i]) begin
                posX_d[i]   = {Ship_X, 7'b0};
                posY_d[i]   = {Ship_Y, 7'b0};
                velX_d[i]   = spawnVelX;
                velY_d[i]   = spawnVelY;
                active_d[i] = 1'b1;
            end else if (active_q[i]) begin
                if ((nextX[i][16:7] > X_LIM) || (nextY[i][16:7] > Y_LIM)) begin
                    active_d[i] = 1'b0;
                end else begin
                    posX_d[i] = nextX[i];
                    posY_d[i] = nextY[i];
                end
            end
        end
        if (spawn) begin
            cool_d  = CD_LOAD;
            shots_d = shots_q + 8'd1;
        end else if (cool_q != '0) begin
            cool_d = cool_q - CW'(1);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_q <= '0;
            cool_q   <= '0;
            shots_q  <= '0;
            for (int i = 0; i < N_BULLETS; i++) begin
                posX_q[i] <= '0;
                posY_q[i] <= '0;
                velX_q[i] <= '0;
                velY_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            cool_q   <= cool_d;
            shots_q  <= shots_d;
            for (int i = 0; i < N_BULLETS; i++) begin
                posX_q[i] <= posX_d[i];
                posY_q[i] <= posY_d[i];
                velX_q[i] <= velX_d[i];
                velY_q[i] <= velY_d[i];
            end
        end
    end

    always_comb begin
        Bullet_X = '0;
        Bullet_Y = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (active_q[i]) begin
                Bullet_X[10*i +: 10] = posX_q[i][16:7];
                Bullet_Y[10*i +: 10] = posY_q[i][16:7];
            end
        end
    end

    assign Bullet_Active = active_q;
    assign Shots_Fired   = shots_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: expected frame snapshots are queued as stimulus is
// driven and compared with immediate assertions after each frame edge.
module tb_bullet_engine;

    logic        frame_clk;
    logic        Reset_n;
    logic [63:0] keycode;
    logic [9:0]  Ship_X, Ship_Y;
    logic [7:0]  X_vec, Y_vec;
    logic [39:0] Bullet_X, Bullet_Y;
    logic [3:0]  Bullet_Active;
    logic [7:0]  Shots_Fired;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [3:0]  act;
        logic [39:0] bx;
        logic [39:0] by;
        logic [7:0]  shots;
    } exp_t;

    exp_t sb[$];

    bullet_engine dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .Ship_X       (Ship_X),
        .Ship_Y       (Ship_Y),
        .X_vec        (X_vec),
        .Y_vec        (Y_vec),
        .Bullet_X     (Bullet_X),
        .Bullet_Y     (Bullet_Y),
        .Bullet_Active(Bullet_Active),
        .Shots_Fired  (Shots_Fired)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish (observed timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic fire, input int keyByte, input int sx, input int sy,
                                 input logic [7:0] xv, input logic [7:0] yv);
        keycode = {8{8'h04}};
        if (fire) keycode[8*keyByte +: 8] = 8'h2C;
        Ship_X = 10'(sx);
        Ship_Y = 10'(sy);
        X_vec  = xv;
        Y_vec  = yv;
    endtask

    task automatic pushExp(input string tag, input logic [3:0] act, input logic [39:0] bx,
                           input logic [39:0] by, input int shots);
        exp_t e;
        e.tag   = tag;
        e.act   = act;
        e.bx    = bx;
        e.by    = by;
        e.shots = 8'(shots);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".active"}, {36'b0, Bullet_Active}, {36'b0, e.act});
            cmp({e.tag, ".x"}, Bullet_X, e.bx);
            cmp({e.tag, ".y"}, Bullet_Y, e.by);
            cmp({e.tag, ".shots"}, {32'b0, Shots_Fired}, {32'b0, e.shots});
        end
    endtask

    task automatic tickCheck();
        @(posedge frame_clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        Reset_n = 1'b0;
        #3;
        Reset_n = 1'b1;
    endtask

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
        return {d[9:0], c[9:0], b[9:0], a[9:0]};
    endfunction

    initial begin
        logic [3:0]  act;
        logic [39:0] bx, by;
        int          shots, cnt, se;

        Reset_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 8'h00, 8'h00);
        #2;
        pushExp("reset_init", 4'b0000, '0, '0, 0);
        checkOutput();
        Reset_n = 1'b1;

        // Single shot; heading and ship position change after spawn must not matter
        applyStimulus(1'b1, 3, 320, 240, 8'h40, 8'h00);
        pushExp("single_spawn", 4'b0001, pk(320, 0, 0, 0), pk(240, 0, 0, 0), 1);
        tickCheck();
        applyStimulus(1'b0, 3, 5, 7, 8'hC0, 8'h40);
        for (int k = 1; k <= 3; k++) begin
            pushExp("single_move", 4'b0001, pk(320 + 2*k, 0, 0, 0), pk(240, 0, 0, 0), 1);
            tickCheck();
        end
        doReset();

        // Auto-fire cadence: spawns at frames 1, 9, 17 into slots 0..2
        applyStimulus(1'b1, 7, 100, 100, 8'h40, 8'h00);
        for (int n = 1; n <= 20; n++) begin
            act = '0; bx = '0; by = '0; shots = 0;
            for (int s = 0; s < 3; s++) begin
                se = 1 + 8*s;
                if (n >= se) begin
                    act[s]        = 1'b1;
                    bx[10*s +: 10] = 10'(100 + 2*(n - se));
                    by[10*s +: 10] = 10'd100;
                    shots++;
                end
            end
            pushExp("autofire", act, bx, by, shots);
            tickCheck();
        end

        // Mid-flight reset with three live bullets, key still held
        Reset_n = 1'b0;
        #1;
        pushExp("reset_midflight", 4'b0000, '0, '0, 0);
        checkOutput();
        #1;
        Reset_n = 1'b1;
        pushExp("post_reset_spawn", 4'b0001, pk(100, 0, 0, 0), pk(100, 0, 0, 0), 1);
        tickCheck();
        doReset();

        // Stationary bullets fill all slots; fifth request is dropped
        applyStimulus(1'b1, 0, 50, 60, 8'h00, 8'h00);
        for (int n = 1; n <= 60; n++) begin
            cnt = (n - 1) / 8 + 1;
            if (cnt > 4) cnt = 4;
            act = '0; bx = '0; by = '0;
            for (int s = 0; s < cnt; s++) begin
                act[s]         = 1'b1;
                bx[10*s +: 10] = 10'd50;
                by[10*s +: 10] = 10'd60;
            end
            pushExp("slots_full", act, bx, by, cnt);
            tickCheck();
        end
        doReset();

        // Right edge retire
        applyStimulus(1'b1, 3, 636, 200, 8'h40, 8'h00);
        pushExp("right_spawn", 4'b0001, pk(636, 0, 0, 0), pk(200, 0, 0, 0), 1);
        tickCheck();
        applyStimulus(1'b0, 3, 636, 200, 8'h40, 8'h00);
        pushExp("right_move", 4'b0001, pk(638, 0, 0, 0), pk(200, 0, 0, 0), 1);
        tickCheck();
        pushExp("right_retire", 4'b0000, '0, '0, 1);
        tickCheck();
        pushExp("right_stay", 4'b0000, '0, '0, 1);
        tickCheck();
        doReset();

        // Bottom edge retire
        applyStimulus(1'b1, 1, 300, 478, 8'h00, 8'h40);
        pushExp("bottom_spawn", 4'b0001, pk(300, 0, 0, 0), pk(478, 0, 0, 0), 1);
        tickCheck();
        applyStimulus(1'b0, 1, 300, 478, 8'h00, 8'h40);
        pushExp("bottom_retire", 4'b0000, '0, '0, 1);
        tickCheck();
        doReset();

        // Left underflow; slot 0 reused once cooldown expires
        applyStimulus(1'b1, 3, 1, 200, 8'hC0, 8'h00);
        for (int n = 1; n <= 10; n++) begin
            shots = (n - 1) / 8 + 1;
            if ((n % 8) == 1)
                pushExp("left_underflow", 4'b0001, pk(1, 0, 0, 0), pk(200, 0, 0, 0), shots);
            else
                pushExp("left_underflow", 4'b0000, '0, '0, shots);
            tickCheck();
        end
        doReset();

        // Retire while all slots full and cooldown idle: refill only on the following frame
        applyStimulus(1'b1, 3, 570, 100, 8'h40, 8'h00);
        for (int n = 1; n <= 40; n++) begin
            act = '0; bx = '0; by = '0;
            if (n <= 35) begin
                act[0] = 1'b1;
                bx[9:0] = 10'(570 + 2*(n - 1));
            end else if (n >= 37) begin
                act[0] = 1'b1;
                bx[9:0] = 10'd570;
            end
            if (act[0]) by[9:0] = 10'd100;
            for (int s = 1; s < 4; s++) begin
                if (n >= 1 + 8*s) begin
                    act[s]         = 1'b1;
                    bx[10*s +: 10] = 10'd570;
                    by[10*s +: 10] = 10'd100;
                end
            end
            if (n < 9) shots = 1;
            else if (n < 17) shots = 2;
            else if (n < 25) shots = 3;
            else if (n < 37) shots = 4;
            else shots = 5;
            pushExp("slot_reuse", act, bx, by, shots);
            tickCheck();
            if (n == 1) applyStimulus(1'b1, 3, 570, 100, 8'h00, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
